// File: rtl/pc_gen.sv
// Next-PC generator for the LEGv8 fetch stage.
// Contains the boot/run/halt sequencer, the prioritised PC select, the
// exception-link register and a circular return-address stack.
module pc_gen #(
  parameter int unsigned     PC_W      = 10,
  parameter int unsigned     INSTR_B   = 4,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [PC_W-1:0] EXC_VEC   = PC_W'('h200),
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            fetch_ready,
  input  logic            stall,
  input  logic            halt_req,
  input  logic            br_valid,
  input  logic [PC_W-1:0] br_target,
  input  logic            exc_valid,
  input  logic [PC_W-1:0] exc_pc,
  input  logic            eret,
  input  logic            ras_push,
  input  logic [PC_W-1:0] ras_push_addr,
  input  logic            ras_pop,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus,
  output logic            fetch_valid,
  output logic            align_fault,
  output logic [PC_W-1:0] elr,
  output logic            ras_empty
);

  localparam int unsigned     OFF_W = $clog2(INSTR_B);
  localparam int unsigned     PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned     CNT_W = PTR_W + 1;
  localparam logic [PC_W-1:0] STEP  = PC_W'(INSTR_B);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(RAS_DEPTH);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   pc_plus_q, pc_plus_d;
  logic [PC_W-1:0]   elr_q, elr_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic              align_fault_q, align_fault_d;
  logic              ras_empty_q, ras_empty_d;
  logic [PC_W-1:0]   ras_q [RAS_DEPTH];
  logic [PTR_W-1:0]  top_q, top_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ras_wr_en;
  logic [PTR_W-1:0]  ras_wr_idx;
  logic              pop_en;
  logic              adv;
  logic              misaligned;

  assign adv        = fetch_valid_q & fetch_ready & ~stall;
  assign misaligned = br_valid & (br_target[OFF_W-1:0] != '0);

  // Sequencer and prioritised next-PC select; redirects bypass the handshake.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    elr_d         = elr_q;
    align_fault_d = 1'b0;
    pop_en        = 1'b0;
    case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN, S_HALT: begin
        if (exc_valid) begin
          pc_d    = EXC_VEC;
          elr_d   = exc_pc;
          state_d = S_RUN;
        end else if (misaligned) begin
          pc_d          = EXC_VEC;
          elr_d         = br_target;
          align_fault_d = 1'b1;
          state_d       = S_RUN;
        end else if (eret) begin
          pc_d    = elr_q;
          state_d = S_RUN;
        end else if (br_valid) begin
          pc_d    = br_target;
          state_d = S_RUN;
        end else if (adv) begin
          pop_en = ras_pop;
          pc_d   = (ras_pop && !ras_empty_q) ? ras_q[top_q] : pc_plus_q;
          if (halt_req) state_d = S_HALT;
        end
      end
      default: state_d = S_BOOT;
    endcase
    pc_plus_d     = pc_d + STEP;
    fetch_valid_d = (state_d == S_RUN);
  end

  // RAS pointer/count update; push+pop replaces the top, full push drops the oldest.
  always_comb begin
    top_d      = top_q;
    cnt_d      = cnt_q;
    ras_wr_en  = 1'b0;
    ras_wr_idx = top_q;
    if (ras_push && pop_en) begin
      ras_wr_en  = 1'b1;
    end else if (ras_push) begin
      ras_wr_en  = 1'b1;
      ras_wr_idx = top_q + PTR_W'(1);
      top_d      = top_q + PTR_W'(1);
      if (cnt_q != FULL) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop_en && (cnt_q != '0)) begin
      top_d = top_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
    ras_empty_d = (cnt_d == '0);
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_PC;
      pc_plus_q     <= RESET_PC + STEP;
      elr_q         <= '0;
      fetch_valid_q <= 1'b0;
      align_fault_q <= 1'b0;
      ras_empty_q   <= 1'b1;
      top_q         <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pc_plus_q     <= pc_plus_d;
      elr_q         <= elr_d;
      fetch_valid_q <= fetch_valid_d;
      align_fault_q <= align_fault_d;
      ras_empty_q   <= ras_empty_d;
      top_q         <= top_d;
      cnt_q         <= cnt_d;
    end
  end

  // RAS storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < RAS_DEPTH; i++) ras_q[PTR_W'(i)] <= '0;
    end else if (ras_wr_en) begin
      ras_q[ras_wr_idx] <= ras_push_addr;
    end
  end

  assign pc          = pc_q;
  assign pc_plus     = pc_plus_q;
  assign elr         = elr_q;
  assign fetch_valid = fetch_valid_q;
  assign align_fault = align_fault_q;
  assign ras_empty   = ras_empty_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen with default parameters.
module tb_pc_gen;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       fetch_ready, stall, halt_req, br_valid, exc_valid, eret;
  logic       ras_push, ras_pop;
  logic [9:0] br_target, exc_pc, ras_push_addr;
  logic [9:0] pc, pc_plus, elr;
  logic       fetch_valid, align_fault, ras_empty;

  int total = 0;
  int bad   = 0;

  pc_gen dut (
    .clk(clk), .reset_n(reset_n), .fetch_ready(fetch_ready), .stall(stall),
    .halt_req(halt_req), .br_valid(br_valid), .br_target(br_target),
    .exc_valid(exc_valid), .exc_pc(exc_pc), .eret(eret),
    .ras_push(ras_push), .ras_push_addr(ras_push_addr), .ras_pop(ras_pop),
    .pc(pc), .pc_plus(pc_plus), .fetch_valid(fetch_valid),
    .align_fault(align_fault), .elr(elr), .ras_empty(ras_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; fetch_ready = 1'b1; stall = 1'b0; halt_req = 1'b0;
    br_valid = 1'b0; br_target = '0; exc_valid = 1'b0; exc_pc = '0;
    eret = 1'b0; ras_push = 1'b0; ras_push_addr = '0; ras_pop = 1'b0;
    step(); step();
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_pc_plus", 32'(pc_plus), 32'h4);
    chk("rst_valid", 32'(fetch_valid), 32'h0);
    chk("rst_empty", 32'(ras_empty), 32'h1);
    chk("rst_elr", 32'(elr), 32'h0);
    chk("rst_align", 32'(align_fault), 32'h0);

    // release: BOOT holds valid low for one cycle
    reset_n = 1'b1;
    step(); chk("boot_pc", 32'(pc), 32'h0); chk("run_valid", 32'(fetch_valid), 32'h1);
    step(); chk("seq_4", 32'(pc), 32'h4);
    step(); chk("seq_8", 32'(pc), 32'h8);
    step(); chk("seq_c", 32'(pc), 32'hC);

    // branch wins over stall
    stall = 1'b1;
    step(); chk("stall_hold", 32'(pc), 32'hC);
    br_valid = 1'b1; br_target = 10'h40;
    step(); chk("br_in_stall", 32'(pc), 32'h40);
    br_valid = 1'b0;
    step(); chk("stall_hold2", 32'(pc), 32'h40);
    stall = 1'b0;

    // exception beats branch, then ERET
    exc_valid = 1'b1; exc_pc = 10'h14; br_valid = 1'b1; br_target = 10'h80;
    step(); chk("exc_pc", 32'(pc), 32'h200); chk("exc_elr", 32'(elr), 32'h14);
    exc_valid = 1'b0; br_valid = 1'b0; eret = 1'b1;
    step(); chk("eret_pc", 32'(pc), 32'h14); chk("eret_plus", 32'(pc_plus), 32'h18);
    eret = 1'b0;

    // misaligned branch target
    br_valid = 1'b1; br_target = 10'h42;
    step(); chk("mis_pc", 32'(pc), 32'h200); chk("mis_elr", 32'(elr), 32'h42);
    chk("mis_fault_hi", 32'(align_fault), 32'h1);
    br_valid = 1'b0; fetch_ready = 1'b0;
    step(); chk("mis_fault_lo", 32'(align_fault), 32'h0); chk("hold_nordy", 32'(pc), 32'h200);

    // RAS overflow: five pushes into four entries
    ras_push = 1'b1;
    ras_push_addr = 10'h10; step();
    chk("push_nonempty", 32'(ras_empty), 32'h0);
    ras_push_addr = 10'h20; step();
    ras_push_addr = 10'h30; step();
    ras_push_addr = 10'h40; step();
    ras_push_addr = 10'h50; step();
    ras_push = 1'b0; fetch_ready = 1'b1; ras_pop = 1'b1;
    step(); chk("pop_50", 32'(pc), 32'h50);
    step(); chk("pop_40", 32'(pc), 32'h40);
    step(); chk("pop_30", 32'(pc), 32'h30);
    step(); chk("pop_20", 32'(pc), 32'h20); chk("ras_empty", 32'(ras_empty), 32'h1);
    step(); chk("pop_empty", 32'(pc), 32'h24); chk("ras_still_empty", 32'(ras_empty), 32'h1);
    ras_pop = 1'b0;

    // wrap-around
    br_valid = 1'b1; br_target = 10'h3FC;
    step(); chk("wrap_pre", 32'(pc), 32'h3FC); chk("wrap_plus", 32'(pc_plus), 32'h0);
    br_valid = 1'b0;
    step(); chk("wrap_pc", 32'(pc), 32'h0);

    // halt after accepted fetch, resume on branch
    halt_req = 1'b1;
    step(); chk("halt_pc", 32'(pc), 32'h4); chk("halt_valid", 32'(fetch_valid), 32'h0);
    halt_req = 1'b0;
    step(); chk("halt_hold", 32'(pc), 32'h4);
    br_valid = 1'b1; br_target = 10'h80;
    step(); chk("resume_pc", 32'(pc), 32'h80); chk("resume_valid", 32'(fetch_valid), 32'h1);
    br_valid = 1'b0;
    step(); chk("resume_seq", 32'(pc), 32'h84);

    // asynchronous reset mid-operation
    ras_push = 1'b1; ras_push_addr = 10'h99;
    step(); ras_push = 1'b0;
    chk("pre_rst_nonempty", 32'(ras_empty), 32'h0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_pc", 32'(pc), 32'h0);
    chk("arst_elr", 32'(elr), 32'h0);
    chk("arst_valid", 32'(fetch_valid), 32'h0);
    chk("arst_empty", 32'(ras_empty), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
